// File: rtl/game_pkg.sv
// Shared types and helpers for the memory game.
//   symbol_t        : 3-bit game symbol 0..7
//   seq_state_t     : round_sequencer state encoding
//   MAX_LEN_DEFAULT : default maximum pattern length
//   onehot8()       : symbol to one-hot LED vector
package game_pkg;

  typedef logic [2:0] symbol_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPEND,
    ST_SHOW_ON,
    ST_SHOW_OFF,
    ST_INPUT,
    ST_GAME_OVER,
    ST_WIN
  } seq_state_t;

  localparam int MAX_LEN_DEFAULT = 25;

  function automatic logic [7:0] onehot8(input symbol_t s);
    onehot8 = 8'b0000_0001 << s;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter used for the show, gap and input-timeout phases.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   load       : load load_val (takes priority over en)
//   load_val   : value to load
//   en         : count down by one; holds at zero
//   done       : count is zero
module phase_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/round_sequencer.sv
// Memory-game round controller: appends a random symbol, plays the pattern
// on the LEDs, then checks the player's presses (forward or reverse recall).
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   start            : new-game pulse (accepted in IDLE / GAME_OVER / WIN)
//   reverse          : recall mode, latched on an accepted start
//   rnd              : random symbol from the LFSR
//   btn_valid, btn   : player press
//   lfsr_en          : advance the LFSR (APPEND only)
//   led              : one-hot symbol display, 0 when dark
//   level, score     : pattern length and completed rounds
//   busy, input_phase, game_over, win : status
// Build option: define ROUND_SEQ_TIMEOUT_EN to end the game when no press
// arrives within TIMEOUT_CYCLES during INPUT; otherwise INPUT waits forever.
//
// state      | meaning
// -----------+---------------------------------------------------
// IDLE       | after reset, waiting for start
// APPEND     | store rnd at pattern[level], level++, advance LFSR
// SHOW_ON    | LED lit with pattern[idx] for SHOW_CYCLES
// SHOW_OFF   | LED dark for GAP_CYCLES, then next symbol or INPUT
// INPUT      | compare presses against the stored pattern
// GAME_OVER  | wrong press or timeout; level/score held
// WIN        | full-length pattern recalled
module round_sequencer
  import game_pkg::*;
#(
  parameter int MAX_LEN        = MAX_LEN_DEFAULT,
  parameter int SHOW_CYCLES    = 16,
  parameter int GAP_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       reverse,
  input  logic [2:0] rnd,
  input  logic       btn_valid,
  input  logic [2:0] btn,
  output logic       lfsr_en,
  output logic [7:0] led,
  output logic [4:0] level,
  output logic [7:0] score,
  output logic       busy,
  output logic       input_phase,
  output logic       game_over,
  output logic       win
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int SG_MAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
`ifdef ROUND_SEQ_TIMEOUT_EN
  localparam int T_MAX = (TIMEOUT_CYCLES > SG_MAX) ? TIMEOUT_CYCLES : SG_MAX;
`else
  localparam int T_MAX = SG_MAX;
`endif
  localparam int TW = $clog2(T_MAX) + 1;

  seq_state_t    state, next_state;
  symbol_t       pattern [MAX_LEN];
  logic [LW-1:0] level_q, idx_q, last_idx, exp_idx;
  logic [7:0]    score_q;
  logic          rev_q;
  logic          can_start, press_hit, press_miss, round_done;
  logic          tmr_load, tmr_en, tmr_done;
  logic [TW-1:0] tmr_val;

  assign last_idx   = level_q - LW'(1);
  // Reverse recall walks the pattern from the newest symbol back.
  assign exp_idx    = rev_q ? (last_idx - idx_q) : idx_q;
  assign can_start  = start && ((state == ST_IDLE) || (state == ST_GAME_OVER) || (state == ST_WIN));
  assign press_hit  = (state == ST_INPUT) && btn_valid && (btn == pattern[exp_idx]);
  assign press_miss = (state == ST_INPUT) && btn_valid && (btn != pattern[exp_idx]);
  assign round_done = press_hit && (idx_q == last_idx);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_GAME_OVER, ST_WIN: if (can_start) next_state = ST_APPEND;
      ST_APPEND:   next_state = ST_SHOW_ON;
      ST_SHOW_ON:  if (tmr_done) next_state = ST_SHOW_OFF;
      ST_SHOW_OFF: if (tmr_done) next_state = (idx_q == last_idx) ? ST_INPUT : ST_SHOW_ON;
      ST_INPUT: begin
        // A press always outranks an expiring timeout in the same cycle.
        if (round_done)      next_state = (level_q == LW'(MAX_LEN)) ? ST_WIN : ST_APPEND;
        else if (press_miss) next_state = ST_GAME_OVER;
`ifdef ROUND_SEQ_TIMEOUT_EN
        else if (!press_hit && tmr_done) next_state = ST_GAME_OVER;
`endif
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    lfsr_en     = (state == ST_APPEND);
    led         = (state == ST_SHOW_ON) ? onehot8(pattern[idx_q]) : 8'h00;
    busy        = !((state == ST_IDLE) || (state == ST_GAME_OVER) || (state == ST_WIN));
    input_phase = (state == ST_INPUT);
    game_over   = (state == ST_GAME_OVER);
    win         = (state == ST_WIN);
    // One timer serves every phase: reload on each state change, and on
    // every accepted press so the timeout measures the gap between presses.
    tmr_en      = 1'b1;
    tmr_load    = (next_state != state) || press_hit;
    tmr_val     = '0;
    case (next_state)
      ST_SHOW_ON:  tmr_val = TW'(SHOW_CYCLES - 1);
      ST_SHOW_OFF: tmr_val = TW'(GAP_CYCLES - 1);
`ifdef ROUND_SEQ_TIMEOUT_EN
      ST_INPUT:    tmr_val = TW'(TIMEOUT_CYCLES);
`endif
      default:     tmr_val = '0;
    endcase
  end

  assign level = 5'(level_q);
  assign score = score_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LEN; i++) pattern[i] <= '0;
      level_q <= '0;
      idx_q   <= '0;
      score_q <= '0;
      rev_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_GAME_OVER, ST_WIN: begin
          if (can_start) begin
            level_q <= '0;
            idx_q   <= '0;
            score_q <= '0;
            rev_q   <= reverse;
          end
        end
        ST_APPEND: begin
          pattern[level_q] <= rnd;
          level_q          <= level_q + LW'(1);
          idx_q            <= '0;
        end
        ST_SHOW_OFF: begin
          if (tmr_done) idx_q <= (idx_q == last_idx) ? '0 : idx_q + LW'(1);
        end
        ST_INPUT: begin
          if (round_done) begin
            idx_q <= '0;
            if (score_q != 8'hFF) score_q <= score_q + 8'd1;
          end else if (press_hit) begin
            idx_q <= idx_q + LW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .done     (tmr_done)
  );

endmodule

// File: tb/tb_round_sequencer.sv
module tb_round_sequencer;

  localparam int ML = 3;
  localparam int SH = 2;
  localparam int GP = 1;
  localparam int TO = 5;

  localparam int EV_SCORE = 0;
  localparam int EV_OVER  = 1;
  localparam int EV_WIN   = 2;
  localparam int EV_LFSR  = 3;
  localparam int EV_LED   = 4;
  localparam int EV_INPUT = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       reverse = 1'b0;
  logic [2:0] rnd = 3'd0;
  logic       btn_valid = 1'b0;
  logic [2:0] btn = 3'd0;
  logic       lfsr_en;
  logic [7:0] led;
  logic [4:0] level;
  logic [7:0] score;
  logic       busy;
  logic       input_phase;
  logic       game_over;
  logic       win;

  always #5 clk = ~clk;

  round_sequencer #(
    .MAX_LEN(ML), .SHOW_CYCLES(SH), .GAP_CYCLES(GP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .reverse(reverse), .rnd(rnd),
    .btn_valid(btn_valid), .btn(btn), .lfsr_en(lfsr_en), .led(led),
    .level(level), .score(score), .busy(busy), .input_phase(input_phase),
    .game_over(game_over), .win(win)
  );

  typedef struct {
    int          kind;
    logic [15:0] data;
  } ev_t;

  ev_t sb[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  int         m_level = 0;
  int         m_score = 0;
  int         m_pidx = 0;
  bit         m_rev = 1'b0;
  logic [2:0] m_pat [ML];

  task automatic push_ev(input int k, input logic [15:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic check_ev(input int k, input logic [15:0] d);
    ev_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL ev_unexpected: got kind=%0d data=%h, required no event", k, d);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.data != d) begin
        n_bad++;
        $display("FAIL ev_order: got kind=%0d data=%h, required kind=%0d data=%h",
                 k, d, e.kind, e.data);
      end
    end
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, got, exp);
    end
  endtask

  // Monitor: turns DUT output activity into events and checks them in order.
  initial begin : monitor
    logic [7:0] p_led;
    logic [7:0] p_score;
    logic       p_in, p_go, p_win;
    int         lit;
    p_led = 0; p_score = 0; p_in = 0; p_go = 0; p_win = 0; lit = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        lit = 0;
      end else begin
        if (score != p_score)       check_ev(EV_SCORE, 16'(score));
        if (game_over && !p_go)     check_ev(EV_OVER, {3'b0, level, score});
        if (win && !p_win)          check_ev(EV_WIN, {3'b0, level, score});
        if (lfsr_en)                check_ev(EV_LFSR, 16'(level));
        if (p_led != 0 && led != p_led) check_ev(EV_LED, {8'(lit), p_led});
        if (input_phase && !p_in)   check_ev(EV_INPUT, 16'(level));
        if (led != 0 && led == p_led) lit++;
        else if (led != 0)            lit = 1;
        else                          lit = 0;
      end
      p_led = led; p_score = score; p_in = input_phase; p_go = game_over; p_win = win;
    end
  end

  task automatic push_round(input logic [2:0] r);
    logic [7:0] oh;
    push_ev(EV_LFSR, 16'(m_level));
    m_pat[m_level] = r;
    m_level++;
    for (int i = 0; i < m_level; i++) begin
      oh = 8'd1 << m_pat[i];
      push_ev(EV_LED, {8'(SH), oh});
    end
    push_ev(EV_INPUT, 16'(m_level));
    m_pidx = 0;
  endtask

  task automatic wait_input(input int limit);
    int k;
    k = 0;
    while (!input_phase && k < limit) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (!input_phase) begin
      n_bad++;
      $display("FAIL wait_input: got input_phase=0 after %0d cycles, required 1", k);
    end
  endtask

  task automatic start_game(input bit rev, input logic [2:0] r, input bit wait_in);
    @(negedge clk);
    if (m_score != 0) push_ev(EV_SCORE, 16'd0);
    m_score = 0;
    m_level = 0;
    m_rev   = rev;
    push_round(r);
    start   = 1'b1;
    reverse = rev;
    rnd     = r;
    @(negedge clk);
    start = 1'b0;
    if (wait_in) wait_input(200);
  endtask

  // Called at a negedge while the DUT is in INPUT.
  task automatic press(input logic [2:0] sym, input logic [2:0] r);
    logic [2:0] ex;
    int mode;
    mode = 0;
    ex = m_rev ? m_pat[m_level - 1 - m_pidx] : m_pat[m_pidx];
    if (sym == ex) begin
      m_pidx++;
      if (m_pidx == m_level) begin
        if (m_score < 255) m_score++;
        push_ev(EV_SCORE, 16'(m_score));
        if (m_level == ML) begin
          push_ev(EV_WIN, {3'b0, 5'(m_level), 8'(m_score)});
          mode = 2;
        end else begin
          push_round(r);
          mode = 1;
        end
      end
    end else begin
      push_ev(EV_OVER, {3'b0, 5'(m_level), 8'(m_score)});
      mode = 2;
    end
    btn = sym;
    rnd = r;
    btn_valid = 1'b1;
    @(negedge clk);
    btn_valid = 1'b0;
    if (mode == 1) wait_input(200);
    else           @(negedge clk);
  endtask

  function automatic logic [31:0] all_outs();
    all_outs = 32'({lfsr_en, led, level, score, busy, input_phase, game_over, win});
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int k;
    // Reset then idle
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_outputs", all_outs(), 32'd0);
    end

    // Forward game: pattern {5,2}, then a wrong press
    start_game(1'b0, 3'd5, 1'b1);
    check("g1_level1", 32'(level), 32'd1);
    press(3'd5, 3'd2);
    check("g1_level2", 32'(level), 32'd2);
    check("g1_score1", 32'(score), 32'd1);
    press(3'd5, 3'd0);
    press(3'd3, 3'd0);
    check("g1_over", 32'(game_over), 32'd1);
    check("g1_busy", 32'(busy), 32'd0);
    check("g1_hold", 32'({level, score}), 32'({5'd2, 8'd1}));

    // Reverse game through to WIN: pattern {3,6,1}
    start_game(1'b1, 3'd3, 1'b1);
    press(3'd3, 3'd6);
    press(3'd6, 3'd0);
    press(3'd3, 3'd1);
    press(3'd1, 3'd0);
    press(3'd6, 3'd0);
    press(3'd3, 3'd0);
    check("win_flag", 32'(win), 32'd1);
    check("win_score", 32'(score), 32'd3);
    repeat (3) begin
      @(negedge clk);
      btn = 3'd1;
      btn_valid = 1'b1;
      @(negedge clk);
      btn_valid = 1'b0;
    end
    check("win_absorb", 32'({win, level, score}), 32'({1'b1, 5'd3, 8'd3}));

    // Restart from WIN; reverse with a wrong first press in round 2
    start_game(1'b1, 3'd3, 1'b1);
    check("restart_lvl_score", 32'({level, score}), 32'({5'd1, 8'd0}));
    press(3'd3, 3'd6);
    press(3'd3, 3'd0);
    check("rev_over", 32'({game_over, level, score}), 32'({1'b1, 5'd2, 8'd1}));

    // Timeout behaviour
    start_game(1'b0, 3'd7, 1'b1);
`ifdef ROUND_SEQ_TIMEOUT_EN
    push_ev(EV_OVER, {3'b0, 5'd1, 8'd0});
    k = 0;
    while (!game_over && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("timeout_over", 32'(game_over), 32'd1);
    n_cmp++;
    if (k < TO || k > TO + 1) begin
      n_bad++;
      $display("FAIL timeout_len: got %0d cycles, required %0d..%0d", k, TO, TO + 1);
    end
`else
    repeat (50) @(negedge clk);
    check("no_timeout", 32'({input_phase, game_over}), 32'({1'b1, 1'b0}));
`endif
    check("sb_empty_pre_reset", 32'(sb.size()), 32'd0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_score = 0;
    m_level = 0;
    check("after_reset", all_outs(), 32'd0);

    // Mid-round reset; start while busy is ignored
    start_game(1'b0, 3'd4, 1'b0);
    k = 0;
    while (led == 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("mid_led", 32'(led), 32'h10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("mid_reset", 32'({led, level, busy, score}), 32'd0);
    sb.delete();
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_reset_idle", all_outs(), 32'd0);
    check("sb_empty_end", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/round_sequencer.md
# round_sequencer

Central controller for the memory game. It owns the stored pattern and sequences each round:
- append one random symbol;
- play the whole pattern on the LEDs with timed on/off phases;
- collect the player's button presses one symbol at a time, forward or reversed;
- end the game on mismatch or timeout, or advance the score and start the next round.

It sits between the LFSR random source, the button debouncer and the LED/score outputs, and replaces the per-mode FSMs with one parameterised sequencer.

## Interface
- MAX_LEN, 25: maximum pattern length in symbols (25 × 3 bits = 75-bit pattern).
- SHOW_CYCLES, 16: cycles each symbol's LED is lit.
- GAP_CYCLES, 8: dark cycles after each displayed symbol.
- TIMEOUT_CYCLES, 256: maximum cycles allowed between accepted presses in the input phase.

- clk  in  1  single clock; all state on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse; starts a new game from IDLE, GAME_OVER or WIN.
- reverse  in  1  mode select; sampled only on an accepted start (0 = forward recall, 1 = reverse recall).
- rnd  in  3  random symbol 0..7 from the LFSR.
- btn_valid  in  1  one-cycle pulse; a player press is present on btn.
- btn  in  3  pressed symbol 0..7.
- lfsr_en  out  1  advance the LFSR; high exactly in APPEND.
- led  out  8  one-hot display of the current symbol, 0 when dark.
- level  out  5  current pattern length, 0..MAX_LEN.
- score  out  8  completed rounds, saturating at 255.
- busy  out  1  high in every state except IDLE, GAME_OVER and WIN.
- input_phase  out  1  high in INPUT.
- game_over  out  1  high while in GAME_OVER.
- win  out  1  high while in WIN.

## Operation
States: IDLE, APPEND, SHOW_ON, SHOW_OFF, INPUT, GAME_OVER, WIN.

- **Reset** (rst_n low at a clk edge) clears everything:
  - state goes to IDLE;
  - the pattern array, level, score, idx and timers are cleared;
  - all outputs are 0.
  - Reset applied mid-round aborts the round with no residual state.
- **IDLE, GAME_OVER, WIN + start:**
  - level and score are cleared;
  - reverse is latched;
  - next state is APPEND.
  - start in any other state is ignored.
- **APPEND** (1 cycle):
  - pattern[level] ← rnd;
  - level ← level+1;
  - lfsr_en = 1;
  - idx ← 0;
  - next state is SHOW_ON.
- **SHOW_ON:**
  - led = 1 << pattern[idx] for SHOW_CYCLES cycles;
  - then SHOW_OFF.
- **SHOW_OFF:**
  - led = 0 for GAP_CYCLES cycles;
  - then idx ← idx+1 and return to SHOW_ON, or, if idx == level-1, go to INPUT with idx ← 0.
- **INPUT:**
  - Expected symbol is pattern[idx] in forward mode, pattern[level-1-idx] in reverse mode.
  - A btn_valid press that equals the expected symbol advances idx.
  - If that press was symbol level-1:
    - score increments, saturating;
    - next state is WIN if level == MAX_LEN, otherwise APPEND.
  - A press that differs from the expected symbol sends the FSM to GAME_OVER. level and score are held for display.
  - btn_valid outside INPUT is ignored.
- **GAME_OVER, WIN:** absorbing states; led = 0. Only start or reset leaves them.
- Arithmetic rules:
  - idx and level are $clog2(MAX_LEN+1) bits wide, and level is zero-extended to 5 bits on output;
  - the phase timers are $clog2 of the largest of SHOW_CYCLES, GAP_CYCLES and TIMEOUT_CYCLES, plus 1 bit;
  - score never wraps.

## Timing
- start accepted at edge N: APPEND is the state during cycle N+1, and the first led is lit in cycle N+2.
- Each symbol occupies exactly SHOW_CYCLES + GAP_CYCLES cycles, so the display phase lasts level × (SHOW_CYCLES + GAP_CYCLES) cycles.
- A press sampled at edge M is judged in the same cycle, and the state, score and idx update at edge M.
- Only one press is consumed per cycle; a btn_valid held high counts as one press per cycle.
- The INPUT timeout counter loads TIMEOUT_CYCLES on entry to INPUT and on every accepted press.
- Simultaneous events:
  - timeout expiry and btn_valid in the same cycle: the press wins.
  - rst_n low and start in the same cycle: reset wins.

## Configuration
- ROUND_SEQ_TIMEOUT_EN defined:
  - when the INPUT timeout counter reaches 0, the FSM goes to GAME_OVER (time-challenge behaviour);
  - score is not incremented.
- ROUND_SEQ_TIMEOUT_EN undefined:
  - the timeout counter and its logic are removed;
  - INPUT waits indefinitely;
  - TIMEOUT_CYCLES is unused.

## Structure
- Shared package game_pkg contains:
  - symbol_t, typedef logic [2:0];
  - the seq_state_t enum;
  - the MAX_LEN_DEFAULT constant;
  - a function onehot8(symbol_t) returning logic [7:0].
- One sub-module, phase_timer:
  - loadable down-counter with inputs load, load_val and en;
  - output done, asserted when the count is 0;
  - shared by SHOW_ON, SHOW_OFF and the INPUT timeout.

## Test plan
- Reset then idle: rst_n low for 2 cycles, then start=0 for 10 cycles → every output stays 0 and state is IDLE.
- Forward round: MAX_LEN=4, SHOW=2, GAP=1, start, rnd=5 → lfsr_en high for 1 cycle, led=8'h20 for 2 cycles then 0 for 1 cycle, input_phase=1. Press btn=5 → score=1, level goes to 2.
- Reverse recall: pattern {3,6}, reverse=1. Press 6 then 3 → score increments. Press 3 first instead → game_over=1 while level=2 and score are held.
- Win: MAX_LEN=2, correct presses in both rounds → win=1, score=2, further btn_valid ignored. Start → level=1, score=0.
- Timeout (macro defined, TIMEOUT_CYCLES=5): no press for 5 cycles in INPUT → game_over=1. Same test with the macro undefined → still INPUT after 50 cycles.
- Mid-round reset: rst_n low during SHOW_ON → next cycle led=0, level=0, busy=0. Start during busy is ignored.
